instruction_fetch: RTL

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/instruction_fetch.sv
// ---------------------------------------------------------------------------
// instruction_fetch
//
// Purpose: fetches instruction words from a request/ack instruction memory
// into a 2-entry {pc, instruction} buffer and presents the head to a
// valid/ready consumer. Supports redirect (flush + new PC) and, optionally,
// halting when an all-zero word is fetched.
//
// Optional feature macro: FETCH_HALT_ON_ZERO_EN
//   defined   : an acked zero word is not buffered, PC holds, fetch halts
//               (o_halted=1) until i_redirect or i_reset.
//   undefined : zero words are ordinary instructions, o_halted tied 0.
//
// Ports:
//   i_clock        in   rising-edge clock
//   i_reset        in   synchronous active-high reset
//   o_mem_req      out  one-cycle read request pulse
//   o_mem_addr     out  read address (current fetch PC)
//   i_mem_ack      in   read data valid, one pulse per request
//   i_mem_data     in   read data, sampled with i_mem_ack
//   o_valid        out  buffer head holds a deliverable instruction
//   i_ready        in   consumer accepts head this cycle
//   o_instruction  out  head instruction (0 when buffer empty)
//   o_pc           out  address the head instruction came from (0 when empty)
//   i_redirect     in   flush and load i_redirect_pc (one-cycle pulse)
//   i_redirect_pc  in   new PC
//   o_halted       out  fetch stopped on a zero word
// ---------------------------------------------------------------------------
module instruction_fetch #(
  parameter int ADDR_WIDTH = 8,
  parameter int INST_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  output logic                  o_mem_req,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  input  logic                  i_mem_ack,
  input  logic [INST_WIDTH-1:0] i_mem_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [INST_WIDTH-1:0] o_instruction,
  output logic [ADDR_WIDTH-1:0] o_pc,
  input  logic                  i_redirect,
  input  logic [ADDR_WIDTH-1:0] i_redirect_pc,
  output logic                  o_halted
);

  typedef enum logic [1:0] {
    S_REQUEST = 2'd0,
    S_WAIT    = 2'd1,
    S_HALTED  = 2'd2
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] pc;
  logic [1:0]            count;
  // Set when a redirect left a read in flight; its ack must be swallowed.
  logic                  discard;

  // Buffer slot 0 is always the head; slot 1 shifts down on pop.
  logic [ADDR_WIDTH-1:0] pc0, pc1;
  logic [INST_WIDTH-1:0] inst0, inst1;

  logic       pop;
  logic       accept;
  logic       zero_word;
  logic       push;
  logic [1:0] occ_after_pop;
  logic       mem_req;

  assign pop    = (count != 2'd0) && i_ready;
  assign accept = (state == S_WAIT) && i_mem_ack;

`ifdef FETCH_HALT_ON_ZERO_EN
  assign zero_word = accept && (i_mem_data == '0);
`else
  assign zero_word = 1'b0;
`endif

  assign push          = accept && !zero_word;
  assign occ_after_pop = count - {1'b0, pop};

  // Requesting only when a slot is guaranteed free means the ack can always
  // be pushed without back-pressure on the memory side.
  assign mem_req = (state == S_REQUEST) && !discard && !i_reset &&
                   !i_redirect && (occ_after_pop != 2'd2);

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state   <= S_REQUEST;
      pc      <= RESET_PC;
      count   <= 2'd0;
      discard <= 1'b0;
    end else if (i_redirect) begin
      state   <= S_REQUEST;
      pc      <= i_redirect_pc;
      count   <= 2'd0;
      // A read is still owed if we were waiting (or already owed one) and
      // its ack is not the one arriving right now.
      discard <= ((state == S_WAIT) || discard) && !i_mem_ack;
    end else begin
      count <= count + {1'b0, push} - {1'b0, pop};
      if (discard && i_mem_ack) begin
        discard <= 1'b0;
      end
      if (push) begin
        pc <= pc + ADDR_WIDTH'(1);
      end
      case (state)
        S_REQUEST: if (mem_req) state <= S_WAIT;
        S_WAIT:    if (accept)  state <= zero_word ? S_HALTED : S_REQUEST;
        S_HALTED:  state <= S_HALTED;
        default:   state <= S_REQUEST;
      endcase
    end
  end

  // Buffer storage; contents are don't-care whenever count says empty.
  always_ff @(posedge i_clock) begin
    if (pop) begin
      pc0   <= pc1;
      inst0 <= inst1;
    end
    if (push) begin
      if (occ_after_pop == 2'd0) begin
        pc0   <= pc;
        inst0 <= i_mem_data;
      end else begin
        pc1   <= pc;
        inst1 <= i_mem_data;
      end
    end
  end

  assign o_mem_req     = mem_req;
  assign o_mem_addr    = pc;
  assign o_valid       = (count != 2'd0);
  assign o_instruction = o_valid ? inst0 : '0;
  assign o_pc          = o_valid ? pc0 : '0;

`ifdef FETCH_HALT_ON_ZERO_EN
  assign o_halted = (state == S_HALTED);
`else
  assign o_halted = 1'b0;
`endif

endmodule
